subtree_event_collector: RTL and testbench

Collects single-cycle event pulses from the ten leaf instances of one subtree level (inst_0..inst_9) and turns them into a serial record stream for the parent level. Each source has a saturating pending-event counter. A round-robin scanner drains the counters into a one-entry output register with a valid/ready handshake. It sits directly downstream of the ten-instance hierarchy node and is its single consumer.

---
 rtl/subtree_event_collector.sv | 122 ++++++++++++
 tb/tb_subtree_event_collector.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtree_event_collector.sv
// subtree_event_collector: per-source saturating event counters drained
// round-robin into a one-entry valid/ready output record register.
module subtree_event_collector #(
    parameter int unsigned NUM_SRC = 10,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_evt,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_src_id,
    output logic [CNT_W-1:0]   out_count,
    output logic [NUM_SRC-1:0] overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [NUM_SRC-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0]              ovf_q, ovf_d;
    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic [ID_W-1:0]                 id_q, id_d;
    logic [CNT_W-1:0]                count_q, count_d;

    logic                            load_c;
    logic                            found_c;
    logic [ID_W-1:0]                 sel_c;
    logic [NUM_SRC-1:0]              drain_c;

    // Output slot can take a new record when empty or being accepted this cycle
    assign load_c = (state_q == ST_EMPTY) || out_ready;

    // Round-robin scan: first nonzero counter after the last-served source
    always_comb begin
        int unsigned idx;
        found_c = 1'b0;
        sel_c   = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (32'(ptr_q) + k) % NUM_SRC;
            if (!found_c && (cnt_q[ID_W'(idx)] != '0)) begin
                found_c = 1'b1;
                sel_c   = ID_W'(idx);
            end
        end
    end

    // Per-source counter update: clr, then drain (keeping a coincident event), then count/saturate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign drain_c[g] = load_c && found_c && (sel_c == ID_W'(g));

        always_comb begin
            cnt_d[g] = cnt_q[g];
            ovf_d[g] = ovf_q[g];
            if (clr) begin
                cnt_d[g] = '0;
                ovf_d[g] = 1'b0;
            end else if (drain_c[g] && src_evt[g]) begin
                cnt_d[g] = CNT_W'(1);
            end else if (drain_c[g]) begin
                cnt_d[g] = '0;
            end else if (src_evt[g]) begin
                if (cnt_q[g] != CNT_MAX) begin
                    cnt_d[g] = cnt_q[g] + CNT_W'(1);
                end else begin
                    ovf_d[g] = 1'b1;
                end
            end
        end
    end

    // Output record FSM: load on free slot, otherwise hold the offered record
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        count_d = count_q;
        if (load_c) begin
            if (found_c) begin
                state_d = ST_FULL;
                id_d    = sel_c;
                count_d = cnt_q[sel_c];
                ptr_d   = sel_c;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // State registers; pointer resets to the last source so source 0 wins first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            ovf_q   <= '0;
            ptr_q   <= ID_W'(NUM_SRC - 1);
            id_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = (state_q == ST_FULL);
    assign out_src_id = id_q;
    assign out_count  = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_subtree_event_collector.sv
// tb_subtree_event_collector: randomized and directed checks against a
// transaction-level model of the event collector.
module tb_subtree_event_collector;

    localparam int unsigned NUM_SRC = 10;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ID_W    = 4;
    localparam int          MAXC    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] src_evt;
    logic               clr;
    logic               out_valid;
    logic               out_ready;
    logic [ID_W-1:0]    out_src_id;
    logic [CNT_W-1:0]   out_count;
    logic [NUM_SRC-1:0] overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                 m_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] m_ovf;
    bit                 m_valid;
    int                 m_id;
    int                 m_count;
    int                 m_last;

    subtree_event_collector #(
        .NUM_SRC(NUM_SRC),
        .CNT_W  (CNT_W),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_evt   (src_evt),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src_id(out_src_id),
        .out_count (out_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] exp_vec();
        return {m_valid, 4'(m_id), 8'(m_count), m_ovf};
    endfunction

    function automatic logic [22:0] act_vec();
        return {out_valid, out_src_id, out_count, overflow};
    endfunction

    // Model of one clock edge, from the behavioural rules
    task automatic model_edge(input logic [NUM_SRC-1:0] evt, input logic c,
                              input logic rdy, input logic rst);
        int pick;
        if (!rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = '0; m_valid = 0; m_id = 0; m_count = 0; m_last = NUM_SRC - 1;
            return;
        end
        pick = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= NUM_SRC; k++)
                if (pick < 0 && m_cnt[(m_last + k) % NUM_SRC] > 0) pick = (m_last + k) % NUM_SRC;
            if (pick >= 0) begin
                m_valid = 1; m_id = pick; m_count = m_cnt[pick]; m_last = pick;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (c) begin
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end else if (i == pick) begin
                m_cnt[i] = evt[i] ? 1 : 0;
            end else if (evt[i]) begin
                if (m_cnt[i] < MAXC) m_cnt[i]++;
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    // Drive at negedge, clock once, update model, return at next negedge
    task automatic step(input logic [NUM_SRC-1:0] evt, input logic c,
                        input logic rdy, input logic rst);
        src_evt = evt; clr = c; out_ready = rdy; rst_n = rst;
        @(posedge clk);
        model_edge(evt, c, rdy, rst);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== 23'd0) begin
            errors++; $display("FAIL reset_state got %h exp %h", act_vec(), 23'd0);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_single_pulse();
        step(10'b00_0000_1000, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency1 got valid=%b exp 0", out_valid);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_src_id, out_count} !== {1'b1, 4'd3, 8'd1}) begin
            errors++; $display("FAIL single_record got v=%b id=%0d cnt=%0d exp v=1 id=3 cnt=1",
                               out_valid, out_src_id, out_count);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_accept got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [NUM_SRC-1:0] e;
        // Occupy the slot with a source-9 record so the next scan starts at 0
        step(10'b10_0000_0000, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            e = '0; e[0] = 1'b1; if (i < 2) e[7] = 1'b1;
            step(e, 1'b0, 1'b0, 1'b1);
            step('0, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if ({out_valid, out_src_id, out_count} !== {1'b1, 4'd9, 8'd1}) begin
            errors++; $display("FAIL bp_hold got v=%b id=%0d cnt=%0d exp v=1 id=9 cnt=1",
                               out_valid, out_src_id, out_count);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_src_id, out_count} !== {1'b1, 4'd0, 8'd5}) begin
            errors++; $display("FAIL bp_rec0 got v=%b id=%0d cnt=%0d exp v=1 id=0 cnt=5",
                               out_valid, out_src_id, out_count);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_src_id, out_count} !== {1'b1, 4'd7, 8'd2}) begin
            errors++; $display("FAIL bp_rec7 got v=%b id=%0d cnt=%0d exp v=1 id=7 cnt=2",
                               out_valid, out_src_id, out_count);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        int sum, exp_id, n;
        sum = 0; exp_id = 0;
        step('0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 30 + 40; c++) begin
            if (c >= 30 && !out_valid) break;
            if (out_valid) begin
                checks++;
                if (out_src_id !== 4'(exp_id)) begin
                    errors++; $display("FAIL rr_order got id=%0d exp %0d", out_src_id, exp_id);
                end
                sum += int'(out_count);
                exp_id = (exp_id + 1) % NUM_SRC;
            end
            step((c < 30) ? '1 : '0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL rr_model got %h exp %h", act_vec(), exp_vec());
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rr_drain_timeout got valid=%b exp 0", out_valid);
        end
        n = sum;
        checks++;
        if (n != 300) begin
            errors++; $display("FAIL rr_total got %0d exp 300", n);
        end
    endtask

    task automatic test_saturation();
        step('0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 300; c++) step(10'b00_0010_0000, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_src_id, out_count, overflow[5]} !== {1'b1, 4'd5, 8'd255, 1'b1}) begin
            errors++; $display("FAIL sat_record got v=%b id=%0d cnt=%0d ovf5=%b exp v=1 id=5 cnt=255 ovf5=1",
                               out_valid, out_src_id, out_count, overflow[5]);
        end
        step('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_src_id, out_count, overflow} !== {1'b1, 4'd5, 8'd255, 10'd0}) begin
            errors++; $display("FAIL sat_clr got v=%b id=%0d cnt=%0d ovf=%b exp v=1 id=5 cnt=255 ovf=0",
                               out_valid, out_src_id, out_count, overflow);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL sat_after_clr got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_drain_event();
        step('0, 1'b0, 1'b0, 1'b0);
        step(10'b00_0000_0100, 1'b0, 1'b1, 1'b1);
        step(10'b00_0000_0100, 1'b0, 1'b1, 1'b1);
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_src_id, out_count} !== {1'b1, 4'd2, 8'd1}) begin
            errors++; $display("FAIL drain_evt got v=%b id=%0d cnt=%0d exp v=1 id=2 cnt=1",
                               out_valid, out_src_id, out_count);
        end
        step(10'b00_0001_0000, 1'b0, 1'b0, 1'b1);
        step(10'b00_0001_0000, 1'b1, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL clr_beats_evt got valid=%b id=%0d cnt=%0d exp valid=0",
                               out_valid, out_src_id, out_count);
        end
    endtask

    task automatic test_reset_midstream();
        step(10'b01_0100_0010, 1'b0, 1'b0, 1'b1);
        step(10'b01_0100_0010, 1'b0, 1'b0, 1'b1);
        step(10'b01_0100_0010, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_held got valid=%b exp 1", out_valid);
        end
        step('0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_count, overflow} !== 19'd0) begin
            errors++; $display("FAIL mid_reset got v=%b cnt=%0d ovf=%b exp all 0",
                               out_valid, out_count, overflow);
        end
        step('0, 1'b0, 1'b1, 1'b1);
        step('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_counters_zero got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] e;
        logic c, r;
        step('0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            e = NUM_SRC'($urandom & $urandom & $urandom);
            if (n >= 800 && n < 1200) e = NUM_SRC'($urandom | $urandom);
            c = ($urandom_range(0, 99) == 0);
            r = (n >= 800 && n < 1200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step(e, c, r, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cycle%0d got %h exp %h", n, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        src_evt = '0; clr = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pulse();
        test_backpressure();
        test_round_robin();
        test_saturation();
        test_drain_event();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
